// File: rtl/uart_pkg.sv
// Shared UART constants: default byte width, receive buffer depth,
// stored-entry field positions and error counter width.
package uart_pkg;
   localparam int UART_DATA_W  = 8;
   localparam int RX_BUF_DEPTH = 8;
   localparam int ENT_DATA_LSB = 0;
   localparam int ENT_PAR      = 8;
   localparam int ENT_STOP     = 9;
   localparam int ERR_CNT_W    = 8;
endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receiver-to-host bundle of uart_rx_buffer: frame capture inputs,
// FWFT read handshake and status. slave = buffer, master = env/host.
interface uart_rx_buffer_if
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int ADDR_W = 3
);
   logic [DATA_W-1:0]    rx_data;
   logic                 rx_parity_err;
   logic                 rx_stop_err;
   logic                 rx_done;
   logic [DATA_W-1:0]    rd_data;
   logic                 rd_parity_err;
   logic                 rd_stop_err;
   logic                 rd_valid;
   logic                 rd_ready;
   logic [ADDR_W:0]      count;
   logic                 full;
   logic                 empty;
   logic                 overflow;
   logic                 clr_overflow;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport slave (
      input  rx_data, rx_parity_err, rx_stop_err, rx_done,
      input  rd_ready, clr_overflow,
      output rd_data, rd_parity_err, rd_stop_err, rd_valid,
      output count, full, empty, overflow, err_cnt
   );

   modport master (
      output rx_data, rx_parity_err, rx_stop_err, rx_done,
      output rd_ready, clr_overflow,
      input  rd_data, rd_parity_err, rd_stop_err, rd_valid,
      input  count, full, empty, overflow, err_cnt
   );
endinterface

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// Ports: push/din write, pop/dout read head, count/full/empty status.
module uart_sync_fifo #(
   parameter int WIDTH  = 10,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty
);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // a full FIFO still takes a write when the head leaves this cycle
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: one FIFO write per rx_done rising edge, overflow
// and error statistics. Ports: clk, reset (async low), bus (slave).
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DATA_W   = UART_DATA_W,
   parameter int DEPTH    = RX_BUF_DEPTH,
   parameter int ADDR_W   = 3,
   parameter int DROP_ERR = 0
) (
   input  logic             clk,
   input  logic             reset,
   uart_rx_buffer_if.slave  bus
);
   logic                 done_q;
   logic                 armed;
   logic                 wr_req;
   logic                 err_frame;
   logic                 drop;
   logic                 push;
   logic                 lost;
   logic                 ovf;
   logic [ERR_CNT_W-1:0] errs;
   logic [DATA_W+1:0]    din;
   logic [DATA_W+1:0]    dout;

   // armed blocks the first cycle after reset so a held rx_done is
   // only seen as a new frame after it falls and rises again
   assign wr_req    = bus.rx_done & ~done_q & armed;
   assign err_frame = bus.rx_parity_err | bus.rx_stop_err;
   assign drop      = (DROP_ERR != 0) & err_frame;
   assign push      = wr_req & ~drop;
   assign lost      = push & bus.full & ~bus.rd_ready;
   assign din       = {bus.rx_stop_err, bus.rx_parity_err, bus.rx_data};

   uart_sync_fifo #(
      .WIDTH  (DATA_W + 2),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (bus.rd_ready),
      .din   (din),
      .dout  (dout),
      .count (bus.count),
      .full  (bus.full),
      .empty (bus.empty)
   );

   assign bus.rd_valid      = ~bus.empty;
   assign bus.rd_data       = dout[DATA_W-1:0];
   assign bus.rd_parity_err = dout[DATA_W];
   assign bus.rd_stop_err   = dout[DATA_W+1];
   assign bus.overflow      = ovf;
   assign bus.err_cnt       = errs;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q <= 1'b0;
         armed  <= 1'b0;
         ovf    <= 1'b0;
         errs   <= '0;
      end else begin
         done_q <= bus.rx_done;
         armed  <= 1'b1;
         if (lost)                  ovf <= 1'b1;
         else if (bus.clr_overflow) ovf <= 1'b0;
         if (wr_req & err_frame & ~&errs)
            errs <= errs + 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Randomized scoreboard bench for uart_rx_buffer (DROP_ERR=0 and 1).
// Queue-based reference model at posedge, monitor compares at negedge.
module tb_uart_rx_buffer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   uart_rx_buffer_if bus ();
   uart_rx_buffer_if dbus ();

   uart_rx_buffer #(.DROP_ERR(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   uart_rx_buffer #(.DROP_ERR(1)) dut_drop (
      .clk   (clk),
      .reset (reset),
      .bus   (dbus.slave)
   );

   assign dbus.rx_data       = bus.rx_data;
   assign dbus.rx_parity_err = bus.rx_parity_err;
   assign dbus.rx_stop_err   = bus.rx_stop_err;
   assign dbus.rx_done       = bus.rx_done;
   assign dbus.clr_overflow  = bus.clr_overflow;
   assign dbus.rd_ready      = 1'b1;

   // reference model: a frame is a rise of rx_done seen since reset
   logic [9:0] exp_q[$];
   logic [9:0] dq[$];
   int  mcount = 0, dcount = 0, merr = 0, derr = 0;
   bit  movf = 0, dovf = 0, mprev = 1;

   always @(posedge clk or negedge reset) begin
      bit wr, err, mpop, dpop;
      logic [9:0] e;
      if (!reset) begin
         exp_q.delete();
         dq.delete();
         mcount = 0; dcount = 0;
         merr = 0; derr = 0;
         movf = 0; dovf = 0;
         mprev = 1;
      end else begin
         wr = bus.rx_done && !mprev;
         mprev = bus.rx_done;
         e = {bus.rx_stop_err, bus.rx_parity_err, bus.rx_data};
         err = bus.rx_stop_err || bus.rx_parity_err;
         mpop = (mcount > 0) && bus.rd_ready;
         dpop = (dcount > 0);
         if (wr && err && merr < 255) merr++;
         if (wr && err && derr < 255) derr++;
         if (wr && mcount == 8 && !mpop) movf = 1;
         else if (bus.clr_overflow) movf = 0;
         if (wr && !err && dcount == 8 && !dpop) dovf = 1;
         else if (bus.clr_overflow) dovf = 0;
         if (mpop) mcount--;
         if (dpop) dcount--;
         if (wr && mcount < 8) begin
            exp_q.push_back(e);
            mcount++;
         end
         if (wr && !err && dcount < 8) begin
            dq.push_back(e);
            dcount++;
         end
      end
   end

   task automatic chk(input string n, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [9:0] e;
      chk("count", bus.count, mcount);
      chk("full", bus.full, mcount == 8);
      chk("empty", bus.empty, mcount == 0);
      chk("rd_valid", bus.rd_valid, mcount > 0);
      chk("overflow", bus.overflow, movf);
      chk("err_cnt", bus.err_cnt, merr);
      chk("count_le_8", bus.count <= 8, 1);
      chk("d_count", dbus.count, dcount);
      chk("d_overflow", dbus.overflow, dovf);
      chk("d_err_cnt", dbus.err_cnt, derr);
      if (!reset) begin
         chk("rst_head", {bus.rd_stop_err, bus.rd_parity_err, bus.rd_data}, 0);
      end else begin
         if (bus.rd_valid && bus.rd_ready) begin
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rd_entry",
                   {bus.rd_stop_err, bus.rd_parity_err, bus.rd_data}, e);
            end
         end
         if (dbus.rd_valid) begin
            if (dq.size() == 0) begin
               chk("d_pop_unexpected", 1, 0);
            end else begin
               e = dq.pop_front();
               chk("d_rd_entry",
                   {dbus.rd_stop_err, dbus.rd_parity_err, dbus.rd_data}, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [7:0] d, input logic p, input logic s,
                        input int hold, input bit rnd);
      bus.rx_data = d;
      bus.rx_parity_err = p;
      bus.rx_stop_err = s;
      bus.rx_done = 1'b1;
      for (int i = 0; i < hold; i++) begin
         if (rnd) bus.rd_ready = 1'($urandom_range(0, 1));
         step();
      end
      bus.rx_done = 1'b0;
      if (rnd) bus.rd_ready = 1'($urandom_range(0, 1));
      step();
   endtask

   task automatic drain();
      int n = 0;
      bus.rd_ready = 1'b1;
      while (!bus.empty && n < 40) begin
         step();
         n++;
      end
      chk("drain_done", bus.empty, 1);
      bus.rd_ready = 1'b0;
      step();
   endtask

   initial begin
      logic p, s;
      bus.rx_data = '0;
      bus.rx_parity_err = 1'b0;
      bus.rx_stop_err = 1'b0;
      bus.rx_done = 1'b0;
      bus.rd_ready = 1'b0;
      bus.clr_overflow = 1'b0;
      repeat (3) step();
      chk("reset_empty", bus.empty, 1);
      reset = 1'b1;
      step();

      frame(8'hA5, 0, 0, 3, 0);
      step();
      chk("single_count", bus.count, 1);
      chk("single_data", bus.rd_data, 8'hA5);
      drain();

      for (int i = 1; i <= 9; i++) frame(8'(i), 0, 0, 1, 0);
      chk("fill_full", bus.full, 1);
      chk("fill_ovf", bus.overflow, 1);
      drain();
      bus.clr_overflow = 1'b1;
      step();
      bus.clr_overflow = 1'b0;
      step();
      chk("ovf_cleared", bus.overflow, 0);

      for (int i = 0; i < 8; i++) frame(8'(8'h10 + i), 0, 0, 1, 0);
      bus.rd_ready = 1'b1;
      frame(8'h18, 0, 0, 1, 0);
      bus.rd_ready = 1'b0;
      chk("wpop_ovf", bus.overflow, 0);
      drain();

      frame(8'h3C, 1, 0, 1, 0);
      frame(8'h3D, 0, 1, 2, 0);
      chk("err_cnt_2", bus.err_cnt, 2);
      chk("drop_count", dbus.count, 0);
      chk("drop_err_cnt", dbus.err_cnt, 2);
      drain();

      for (int i = 0; i < 20; i++)
         frame(8'($urandom), 0, 0, 1, 1);
      for (int i = 0; i < 300; i++) begin
         p = 1'($urandom_range(0, 1));
         s = p ? 1'($urandom_range(0, 1)) : 1'b1;
         frame(8'($urandom), p, s, $urandom_range(1, 2), 1);
      end
      drain();
      bus.clr_overflow = 1'b1;
      step();
      bus.clr_overflow = 1'b0;
      chk("err_sat", bus.err_cnt, 255);
      chk("d_err_sat", dbus.err_cnt, 255);

      for (int i = 0; i < 5; i++) frame(8'(8'h60 + i), 0, 0, 1, 0);
      bus.rx_data = 8'h70;
      bus.rx_done = 1'b1;
      reset = 1'b0;
      step();
      reset = 1'b1;
      repeat (3) step();
      chk("mrst_count", bus.count, 0);
      chk("mrst_err", bus.err_cnt, 0);
      bus.rx_done = 1'b0;
      step();
      frame(8'h77, 0, 0, 1, 0);
      chk("mrst_rewrite", bus.count, 1);
      drain();

      chk("exp_q_left", exp_q.size(), 0);
      chk("dq_left", dq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
